pwd_mode_ctrl: RTL and testbench
================================

Name: pwd_mode_ctrl

Overview:
Top-level mode controller for the 3-digit combination lock. It debounces the user buttons and drives the 5-bit mode code and the password-latch qualifier into the sequence checker. It consumes the checker's status LEDs (pass, third failure) to decide between open, retry and lockout. It is the initiator side of the mode/status interface that the checker responds to.

Parameters:
DEB_CYCLES, 20, number of consecutive stable samples before a button level is accepted (set 1_000_000 for the board build).
VERIFY_WIN, 16, cycles spent in VERIFY per attempt. Must be >= 12 so the checker's 10-cycle attempt counter plus one LED-update cycle completes.
LOCK_CYCLES, 64, lockout duration in cycles.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_set  in  1  raw button: start (re)setting the password
btn_confirm  in  1  raw button: confirm the entered password
btn_verify  in  1  raw button: start a verification attempt
gled1  in  1  checker pass indication, same clock domain
rled2  in  1  checker third-failure indication, same clock domain
big_state  out  5  mode code to checker: 0 IDLE, 1 SET, 2 CONFIRM, 3 PREP, 4 VERIFY, 5 OPEN, 6 LOCK
test  out  1  password-latch inhibit: 0 only while big_state==CONFIRM, 1 otherwise
unlocked  out  1  high while in OPEN
locked  out  1  high while in LOCK

Behaviour:
- Reset values: big_state=0 (IDLE), test=1, unlocked=0, locked=0, timer=0, all debouncer state cleared, no pulses.
- All outputs are registered or decoded from the state register only. No combinational path from inputs to outputs.
- Button path, per button:
  - 2-flop synchroniser, then a stable counter.
  - The accepted level changes after DEB_CYCLES identical consecutive samples.
  - A 1-cycle pulse is generated on a 0->1 change of the accepted level.
  - The state register acts on a pulse in the cycle after it is generated.
  - A held button produces exactly one pulse. Glitches shorter than DEB_CYCLES produce none.
- Simultaneous pulses: priority is set > confirm > verify. Lower-priority pulses in that cycle are dropped.
- Transitions (any event not listed holds the current state):
  - IDLE: set -> SET.
  - SET: confirm -> CONFIRM.
  - CONFIRM: unconditional after exactly 1 cycle -> PREP. The checker latches the password in this cycle since test=0.
  - PREP: set -> SET; verify -> VERIFY with timer cleared to 0.
  - VERIFY: timer increments each cycle. Checks are evaluated in this priority order:
    - gled1==1 -> OPEN.
    - else rled2==1 -> LOCK with timer cleared.
    - else timer==VERIFY_WIN-1 -> PREP. This is a failed attempt; the checker lit the next red LED.
    - Button pulses are ignored in VERIFY.
  - OPEN: set -> SET. Verify and confirm pulses are ignored, because gled1 stays high until the checker sees SET.
  - LOCK: all buttons are ignored. Timer increments; timer==LOCK_CYCLES-1 -> SET. Passing through SET clears the checker LEDs, so the password must be re-entered.
- Timer: one shared counter of width clog2(max(VERIFY_WIN, LOCK_CYCLES)). It is cleared on entry to VERIFY or LOCK and holds in all other states.
- Asserting rst mid-VERIFY or mid-LOCK returns to IDLE immediately (asynchronous). Partial debounce counts are discarded.
- Encodings 7 is unused. Any illegal state value recovers to IDLE on the next clock.

Decomposition:
- Shared package/header: the mode-code constants IDLE..LOCK (5-bit). The checker already uses values 1..4 for SET/CONFIRM/PREP/VERIFY; this block adds 0, 5 and 6.
- One sub-module, btn_debounce (parameter DEB_CYCLES; ports clk, rst, raw, pulse). It is instantiated three times.
- FSM and timer stay in the top module.

Test Plan:
- Reset then idle: hold rst 3 cycles, release, no buttons -> big_state=0, test=1, unlocked=0, locked=0 for 100 cycles.
- Set/confirm: press set 40 cycles, then confirm 40 cycles -> big_state goes 0->1, then 1->2 for exactly one cycle with test=0, then 3 with test=1.
- Pass: from PREP press verify; drive gled1=1 at VERIFY cycle 11 -> big_state=5 and unlocked=1 the next cycle; a verify press in OPEN leaves big_state at 5.
- Three fails then lockout:
  - Stimulus: from PREP, three verify presses with gled1=0; rled2 is raised during the third attempt.
  - Attempts 1 and 2: each returns to 3 after exactly 16 cycles in state 4.
  - Attempt 3: rled2=1 gives big_state=6 and locked=1 the next cycle.
  - Lockout: after exactly 64 cycles big_state=1 and locked=0.
- Debounce: 10-cycle glitches on btn_set in IDLE -> no state change; a 5 µs clean press -> exactly one transition to SET.
- Priority/reset: set and verify pulses in the same cycle in PREP -> SET; rst asserted mid-LOCK -> big_state=0 asynchronously, locked=0.

Source files
------------

// File: rtl/pwd_mode_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | pwd_mode_ctrl_pkg: mode codes shared with the sequence checker   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package pwd_mode_ctrl_pkg;

  typedef logic [4:0] mode_t;

  // The checker already decodes 1..4; 0, 5 and 6 are local to this controller.
  localparam mode_t MODE_IDLE    = 5'd0;
  localparam mode_t MODE_SET     = 5'd1;
  localparam mode_t MODE_CONFIRM = 5'd2;
  localparam mode_t MODE_PREP    = 5'd3;
  localparam mode_t MODE_VERIFY  = 5'd4;
  localparam mode_t MODE_OPEN    = 5'd5;
  localparam mode_t MODE_LOCK    = 5'd6;

endpackage

`default_nettype wire

// File: rtl/pwd_mode_ctrl_btn_debounce.sv
// +------------------------------------------------------------------+
// | btn_debounce: 2-flop sync, stable counter, rising-level pulse    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module btn_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/pwd_mode_ctrl.sv
// +------------------------------------------------------------------+
// | pwd_mode_ctrl: combination-lock mode FSM driving the checker     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module pwd_mode_ctrl
  import pwd_mode_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = 20,
  parameter int VERIFY_WIN  = 16,
  parameter int LOCK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_set,
  input  logic       btn_confirm,
  input  logic       btn_verify,
  input  logic       gled1,
  input  logic       rled2,
  output logic [4:0] big_state,
  output logic       test,
  output logic       unlocked,
  output logic       locked
);

  localparam int TMAX = (VERIFY_WIN > LOCK_CYCLES) ? VERIFY_WIN : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX);

  logic set_p, confirm_p, verify_p;
  logic ev_set, ev_confirm, ev_verify;

  mode_t         state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk(clk), .rst(rst), .raw(btn_set), .pulse(set_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_confirm (
    .clk(clk), .rst(rst), .raw(btn_confirm), .pulse(confirm_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_verify (
    .clk(clk), .rst(rst), .raw(btn_verify), .pulse(verify_p)
  );

  assign ev_set     = set_p;
  assign ev_confirm = confirm_p & ~set_p;
  assign ev_verify  = verify_p & ~set_p & ~confirm_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MODE_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      MODE_IDLE:    if (ev_set) state_d = MODE_SET;
      MODE_SET:     if (ev_confirm) state_d = MODE_CONFIRM;
      MODE_CONFIRM: state_d = MODE_PREP;
      MODE_PREP: begin
        if (ev_set) begin
          state_d = MODE_SET;
        end else if (ev_verify) begin
          state_d = MODE_VERIFY;
          timer_d = '0;
        end
      end
      MODE_VERIFY: begin
        timer_d = timer_q + TW'(1);
        if (gled1) begin
          state_d = MODE_OPEN;
        end else if (rled2) begin
          state_d = MODE_LOCK;
          timer_d = '0;
        end else if (timer_q == TW'(VERIFY_WIN - 1)) begin
          state_d = MODE_PREP;
        end
      end
      MODE_OPEN:    if (ev_set) state_d = MODE_SET;
      MODE_LOCK: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(LOCK_CYCLES - 1)) state_d = MODE_SET;
      end
      default:      state_d = MODE_IDLE;
    endcase
  end

  // Outputs decode the state register only, so no input reaches them combinationally.
  always_comb begin
    big_state = state_q;
    test      = 1'b1;
    unlocked  = 1'b0;
    locked    = 1'b0;
    case (state_q)
      MODE_CONFIRM: test     = 1'b0;
      MODE_OPEN:    unlocked = 1'b1;
      MODE_LOCK:    locked   = 1'b1;
      default:      ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pwd_mode_ctrl.sv
// +------------------------------------------------------------------+
// | tb_pwd_mode_ctrl: directed self-checking bench for pwd_mode_ctrl |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_pwd_mode_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_set, btn_confirm, btn_verify;
  logic       gled1, rled2;
  logic [4:0] big_state;
  logic       test, unlocked, locked;

  int n_checks;
  int n_fails;

  pwd_mode_ctrl #(.DEB_CYCLES(20), .VERIFY_WIN(16), .LOCK_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .btn_set(btn_set), .btn_confirm(btn_confirm), .btn_verify(btn_verify),
    .gled1(gled1), .rled2(rled2),
    .big_state(big_state), .test(test), .unlocked(unlocked), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [4:0] target, input string tag);
    int n;
    n = 0;
    while (big_state !== target && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, big_state, target);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    btn_set = 1'b0; btn_confirm = 1'b0; btn_verify = 1'b0;
    gled1 = 1'b0; rled2 = 1'b0;

    // Reset and quiet idle
    cycles(3);
    check_val("rst_outputs", {big_state, test, unlocked, locked}, {5'd0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_val("idle_hold", {big_state, test, unlocked, locked}, {5'd0, 1'b1, 1'b0, 1'b0});
    end

    // Short glitches must never be accepted
    for (int i = 0; i < 5; i++) begin
      btn_set = 1'b1; cycles(10);
      btn_set = 1'b0; cycles(10);
    end
    cycles(30);
    check_val("glitch_idle", big_state, 5'd0);

    // Clean 5 us press: one move to SET, held button changes nothing more
    btn_set = 1'b1;
    wait_state(5'd1, "set_press");
    cycles(470);
    check_val("set_held", big_state, 5'd1);
    btn_set = 1'b0;
    cycles(30);

    // Confirm: CONFIRM for exactly one cycle with test low, then PREP
    btn_confirm = 1'b1;
    wait_state(5'd2, "confirm_enter");
    check_val("confirm_test", test, 1'b0);
    @(negedge clk);
    check_val("prep_after_confirm", big_state, 5'd3);
    check_val("prep_test", test, 1'b1);
    cycles(20);
    btn_confirm = 1'b0;
    cycles(30);

    // Pass on VERIFY cycle 11
    btn_verify = 1'b1;
    wait_state(5'd4, "verify_enter");
    cycles(11);
    check_val("verify_cyc11", big_state, 5'd4);
    gled1 = 1'b1;
    @(negedge clk);
    check_val("open_state", big_state, 5'd5);
    check_val("open_unlocked", unlocked, 1'b1);
    btn_verify = 1'b0;
    cycles(30);
    btn_verify = 1'b1;
    cycles(40);
    check_val("open_ignore_verify", big_state, 5'd5);
    btn_verify = 1'b0;
    cycles(30);

    // Back to SET then PREP
    btn_set = 1'b1;
    wait_state(5'd1, "open_to_set");
    gled1 = 1'b0;
    btn_set = 1'b0;
    cycles(30);
    btn_confirm = 1'b1;
    wait_state(5'd3, "reconfirm_prep");
    btn_confirm = 1'b0;
    cycles(30);

    // Two timed-out attempts of exactly 16 cycles
    for (int a = 0; a < 2; a++) begin
      btn_verify = 1'b1;
      wait_state(5'd4, "fail_verify_enter");
      cycles(15);
      check_val("fail_cyc15", big_state, 5'd4);
      @(negedge clk);
      check_val("fail_back_prep", big_state, 5'd3);
      btn_verify = 1'b0;
      cycles(30);
    end

    // Third attempt hits rled2, then 64-cycle lockout
    btn_verify = 1'b1;
    wait_state(5'd4, "third_verify_enter");
    cycles(5);
    rled2 = 1'b1;
    @(negedge clk);
    check_val("lock_state", big_state, 5'd6);
    check_val("lock_flag", locked, 1'b1);
    rled2 = 1'b0;
    btn_verify = 1'b0;
    cycles(63);
    check_val("lock_cyc63", big_state, 5'd6);
    @(negedge clk);
    check_val("lock_exit_set", big_state, 5'd1);
    check_val("lock_exit_flag", locked, 1'b0);

    // Set beats verify in the same cycle from PREP
    btn_confirm = 1'b1;
    wait_state(5'd3, "prio_prep");
    btn_confirm = 1'b0;
    cycles(30);
    btn_set = 1'b1;
    btn_verify = 1'b1;
    wait_state(5'd1, "prio_set_wins");
    cycles(2);
    check_val("prio_stay_set", big_state, 5'd1);
    btn_set = 1'b0;
    btn_verify = 1'b0;
    cycles(30);

    // Asynchronous reset in the middle of LOCK
    btn_confirm = 1'b1;
    wait_state(5'd3, "rst_prep");
    btn_confirm = 1'b0;
    cycles(30);
    btn_verify = 1'b1;
    wait_state(5'd4, "rst_verify");
    rled2 = 1'b1;
    @(negedge clk);
    check_val("rst_lock_entered", big_state, 5'd6);
    rled2 = 1'b0;
    btn_verify = 1'b0;
    cycles(10);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_state", big_state, 5'd0);
    check_val("async_rst_locked", locked, 1'b0);
    cycles(2);
    rst = 1'b0;
    cycles(5);
    check_val("post_rst_idle", big_state, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
